au_cmp_eq_seq: RTL
==================

# au_cmp_eq_seq

Multi-cycle sequencer for equality comparison of wide operands. It captures two WIDTH-bit words on a start request and walks them slice by slice through one SLICE-bit equality comparator. It can stop at the first mismatching slice and reports the equality result and the index of the first differing slice. It sits in front of the AU equality datapath wherever a full-width single-cycle comparator is too large or too slow.

## Interface
- WIDTH, 32, operand word length (>= 1)
- SLICE, 8, bits compared per cycle (1 <= SLICE <= WIDTH)
- EARLY_EXIT, 1, 1: finish on first mismatching slice; 0: always scan all slices
- Derived: NSLICE = ceil(WIDTH/SLICE); IDXW = max(1, clog2(NSLICE))
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only in IDLE
- a  in  WIDTH  operand, sampled on the accepting edge
- b  in  WIDTH  operand, sampled on the accepting edge
- busy  out  1  high whenever state != IDLE
- done  out  1  single-cycle pulse: result valid
- eq  out  1  1 = a equal b (all slices matched)
- mis_idx  out  IDXW  index of the lowest-numbered mismatching slice; 0 when eq = 1

## Operation
- Slice k covers bits [k*SLICE +: SLICE], with slice 0 at the LSBs.
- The last slice is zero-padded above bit WIDTH-1 in both operands, so padding always matches.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start = 1, register a and b into internal operand registers and clear the slice counter cnt to 0.
  - Clear the match flag, then go to RUN.
- RUN, each cycle, compare slice cnt of the captured operands:
  - On mismatch, record mis_idx = cnt and eq = 0. If EARLY_EXIT = 1, go to DONE.
  - If EARLY_EXIT = 0, record only the first mismatch; later mismatches leave mis_idx unchanged.
  - If cnt = NSLICE-1, go to DONE. Set eq = 1 only if no slice mismatched.
  - Otherwise increment cnt.
- DONE: assert done for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE; there is no queuing. A start held high through DONE is accepted in the following IDLE cycle.
- Input a and b are don't-care after capture; changes do not affect an operation in flight.
- eq and mis_idx update only at completion and hold until the next accepted start. They are not cleared by start.
- NSLICE = 1 is legal: RUN lasts one cycle.
- Parameters are legal when WIDTH >= 1 and 1 <= SLICE <= WIDTH. Illegal parameters print an error and call $finish at elaboration/initial time.

## Timing
- Reset state: IDLE, cnt = 0. Outputs: busy = 0, done = 0, eq = 0, mis_idx = 0.
- Reset has priority over all other activity. Reset asserted in any state returns to IDLE on the next edge and aborts any operation with no done pulse.
- Cycle numbering: start is sampled high at the edge ending cycle 0.
- RUN occupies cycles 1..NSLICE for a full scan.
- For a full scan, done = 1 in cycle NSLICE+1.
- With EARLY_EXIT = 1 and the first mismatch at slice k, done = 1 in cycle k+2.
- busy is high from cycle 1 through the done cycle inclusive.
- Back-to-back throughput: one operation per NSLICE+2 cycles. The next start can be accepted at the earliest in the cycle after done.
- eq and mis_idx are valid in the done cycle and stable until the next completion.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset behaviour: drive rst for 2 cycles with start = 1.
  - Required: busy = 0, done = 0, eq = 0, mis_idx = 0, and no operation starts while rst = 1.
- Equal operands (WIDTH = 32, SLICE = 8): a = b = 0xDEADBEEF, start in cycle 0.
  - Required: busy high in cycles 1..5, done pulse in cycle 5, eq = 1, mis_idx = 0.
- First-slice mismatch: a = 0x12345678, b = 0x12345679.
  - EARLY_EXIT = 1: done in cycle 2, eq = 0, mis_idx = 0.
  - EARLY_EXIT = 0: done in cycle 5, eq = 0, mis_idx = 0.
- Upper-slice and multiple mismatches:
  - a = 0xFF000000, b = 0: done in cycle 5, eq = 0, mis_idx = 3.
  - a = 0x00FF0000 XOR 0x0000FF00 applied against b = 0: mismatching slices are 1 and 2. Required: mis_idx = 1; with EARLY_EXIT = 1, done in cycle 3.
- Robustness:
  - start pulses during RUN are ignored, and changing a and b after capture does not alter the result.
  - rst asserted in cycle 2 of an operation gives IDLE in cycle 3, no done pulse, and outputs at reset values.
- Padding (WIDTH = 10, SLICE = 4, NSLICE = 3): a = 0x3FF, b = 0x1FF.
  - Required: eq = 0, mis_idx = 2, done in cycle 4 with EARLY_EXIT = 1.

Source files
------------

// File: rtl/au_cmp_eq_seq_if.sv
// au_cmp_eq_seq_if: request/result bundle between a requester and the slice-serial equality sequencer.
interface au_cmp_eq_seq_if #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
);
  localparam int NSLICE = (WIDTH + SLICE - 1) / (SLICE < 1 ? 1 : SLICE);
  localparam int IDXW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic [IDXW-1:0]  mis_idx;
  modport master (output start, a, b, input busy, done, eq, mis_idx);
  modport slave (input start, a, b, output busy, done, eq, mis_idx);
endinterface

// File: rtl/au_cmp_eq_seq.sv
// au_cmp_eq_seq: walks two captured words slice by slice through one SLICE-bit equality compare.
module au_cmp_eq_seq #(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter int EARLY_EXIT = 1
) (
  input logic            clk,
  input logic            rst,
  au_cmp_eq_seq_if.slave s
);
  localparam int NSLICE = (WIDTH + SLICE - 1) / (SLICE < 1 ? 1 : SLICE);
  localparam int IDXW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  localparam int PW = NSLICE * SLICE;
  if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH) begin : g_bad
    $error("au_cmp_eq_seq: illegal parameters WIDTH=%0d SLICE=%0d", WIDTH, SLICE);
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   x_q, x_d;
  logic [IDXW-1:0] cnt_q, cnt_d, idx_q, idx_d, mis_q, mis_d;
  logic            mm_q, mm_d, eq_q, eq_d, cur, fin;
  // Only the XOR of the operands matters; zero-extension makes the padded bits match.
  assign cur = |x_q[SLICE-1:0];
  assign fin = (EARLY_EXIT != 0 && cur) || cnt_q == IDXW'(NSLICE - 1);
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: if (s.start) begin
        x_d     = PW'(s.a) ^ PW'(s.b);
        cnt_d   = '0;
        mm_d    = 1'b0;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        x_d   = x_q >> SLICE;
        mm_d  = mm_q | cur;
        idx_d = (cur && !mm_q) ? cnt_q : idx_q;
        if (fin) begin
          eq_d    = !(mm_q || cur);
          mis_d   = mm_q ? idx_q : (cur ? cnt_q : '0);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      mm_q    <= 1'b0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      mm_q    <= mm_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      mis_q   <= mis_d;
    end
  end
  assign s.busy    = state_q != IDLE;
  assign s.done    = state_q == DONE;
  assign s.eq      = eq_q;
  assign s.mis_idx = mis_q;
endmodule
